mem_arbiter: RTL

Parametrised byte-bus arbiter between N requesting masters (instruction fetch, load/store, …) and the single 8-bit memory/IO bus of the top level. It serialises multi-byte (1–4 byte) read and write transactions onto the byte bus and decodes RAM versus IO space. It tracks the one-cycle read latency of the synchronous RAM so returned bytes are steered by a registered region flag rather than the current address. It honours the top-level `rdy_in` pause (debug break) without losing in-flight read data.

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Round-robin byte-bus arbiter: serialises 1-4 byte master transactions onto the
// 8-bit memory/IO bus and steers returned read bytes by a registered region flag.
module mem_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int RAM_ADDR_WIDTH = 17
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       rdy_in,
   input  logic [NUM_MASTERS-1:0]     m_req,
   input  logic [NUM_MASTERS-1:0]     m_wr,
   input  logic [32*NUM_MASTERS-1:0]  m_addr,
   input  logic [3*NUM_MASTERS-1:0]   m_len,
   input  logic [32*NUM_MASTERS-1:0]  m_wdata,
   output logic [NUM_MASTERS-1:0]     m_done,
   output logic [31:0]                m_rdata,
   output logic [31:0]                mem_a,
   output logic                       mem_wr,
   output logic [7:0]                 mem_dout,
   output logic                       io_en,
   input  logic [7:0]                 ram_din,
   input  logic [7:0]                 io_din
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] next_ptr;
   logic             win_vld;
   logic             grant;

   logic [31:0] sel_addr;
   logic [2:0]  sel_len;
   logic        sel_wr;
   logic [31:0] sel_wdata;

   logic [31:0]      cur_base;
   logic [1:0]       cur_last;
   logic             cur_wr;
   logic [31:0]      cur_wdata;
   logic [IDX_W-1:0] cur_id;
   logic [1:0]       cnt;

   logic        pend_v;
   logic [1:0]  pend_idx;
   logic        pend_io;
   logic [31:0] rd_buf;

   logic issue;
   logic last_issue;

   function automatic logic [IDX_W-1:0] wrap_idx(input int v);
      return IDX_W'(v % NUM_MASTERS);
   endfunction

   // Lengths outside 1..4 are clamped; only the index of the final byte is kept
   function automatic logic [1:0] last_of(input logic [2:0] len);
      case (len)
         3'd0, 3'd1: return 2'd0;
         3'd2:       return 2'd1;
         3'd3:       return 2'd2;
         default:    return 2'd3;
      endcase
   endfunction

   // Search starts at the round-robin pointer so the most recent winner goes last
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (!win_vld && m_req[wrap_idx(int'(rr_ptr) + k)]) begin
            win_vld = 1'b1;
            win_idx = wrap_idx(int'(rr_ptr) + k);
         end
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_len   = '0;
      sel_wr    = 1'b0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (win_idx == IDX_W'(i)) begin
            sel_addr  = m_addr[32*i +: 32];
            sel_len   = m_len[3*i +: 3];
            sel_wr    = m_wr[i];
            sel_wdata = m_wdata[32*i +: 32];
         end
      end
   end

   assign next_ptr   = (int'(win_idx) == NUM_MASTERS - 1) ? '0 : win_idx + 1'b1;
   assign grant      = (state_q == IDLE) && rdy_in && win_vld;
   assign issue      = (state_q == XFER) && rdy_in;
   assign last_issue = issue && (cnt == cur_last);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (grant) state_d = XFER;
         XFER: if (last_issue) state_d = cur_wr ? DONE : WAIT;
         WAIT: state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_a    = '0;
      mem_wr   = 1'b0;
      mem_dout = '0;
      m_done   = '0;
      m_rdata  = '0;
      case (state_q)
         XFER: begin
            mem_a    = cur_base + {30'd0, cnt};
            mem_wr   = cur_wr & rdy_in;
            mem_dout = cur_wdata[{cnt, 3'b000} +: 8];
         end
         DONE: begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
               m_done[i] = (cur_id == IDX_W'(i));
            end
            m_rdata = rd_buf;
         end
         default: ;
      endcase
   end

   assign io_en = (mem_a[RAM_ADDR_WIDTH -: 2] == 2'b11);

   // Transaction context is captured at grant so masters may drop or change
   // their inputs while the transfer is still running
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rr_ptr    <= '0;
         cur_base  <= '0;
         cur_last  <= '0;
         cur_wr    <= 1'b0;
         cur_wdata <= '0;
         cur_id    <= '0;
         cnt       <= '0;
      end else if (grant) begin
         rr_ptr    <= next_ptr;
         cur_base  <= sel_addr;
         cur_last  <= last_of(sel_len);
         cur_wr    <= sel_wr;
         cur_wdata <= sel_wdata;
         cur_id    <= win_idx;
         cnt       <= '0;
      end else if (issue && !last_issue) begin
         cnt <= cnt + 2'd1;
      end
   end

   // Read return path: the region is remembered at issue time so the byte
   // arriving a cycle later is steered correctly whatever mem_a shows by then
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pend_v   <= 1'b0;
         pend_idx <= '0;
         pend_io  <= 1'b0;
         rd_buf   <= '0;
      end else begin
         pend_v   <= issue && !cur_wr;
         pend_idx <= cnt;
         pend_io  <= io_en;
         if (grant) begin
            rd_buf <= '0;
         end else if (pend_v) begin
            rd_buf[{pend_idx, 3'b000} +: 8] <= pend_io ? io_din : ram_din;
         end
      end
   end

endmodule
